// File: rtl/rf_pkg.sv
// Shared register-file constants and flattened-port slicing helper.
// Used by the register file and by the decode/writeback stages.
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

   // Bit offset of port 'port' inside a flattened bus of 'width'-bit fields.
   function automatic int rf_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, all cleared on flush.
// Issue wins over a same-cycle retirement to the same register (younger producer).
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 1
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iss_v,
   input  logic [ADDR_W-1:0]      iss_rd,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wa,
   input  logic                   flush,
   output logic [2**ADDR_W-1:0]   busy,
   output logic                   busy_any
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DEPTH-1:0] busy_reg;
   logic [DEPTH-1:0] busy_next;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_busy
         logic set_b;
         logic clr_b;
         assign set_b = iss_v && (iss_rd == ADDR_W'(gi)) && !((ZERO_REG != 0) && (gi == 0));
         assign clr_b = we && (wa == ADDR_W'(gi));
         assign busy_next[gi] = flush ? 1'b0 :
                                set_b ? 1'b1 :
                                clr_b ? 1'b0 : busy_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg <= '0;
      end else begin
         busy_reg <= busy_next;
      end
   end

   assign busy     = busy_reg;
   assign busy_any = |busy_reg;

endmodule

// File: rtl/rf_param_sb.sv
// Parametrised register file with combinational read ports, optional write-to-read
// bypass, optional hardwired-zero r0 and a per-register RAW scoreboard.
module rf_param_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wa,
   input  logic [DATA_W-1:0]          wd,
   input  logic [NUM_RD*ADDR_W-1:0]   ra,
   output logic [NUM_RD*DATA_W-1:0]   rd,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       iss_v,
   input  logic [ADDR_W-1:0]          iss_rd,
   input  logic                       flush,
   output logic                       busy_any
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wr_ok;

   // A write to r0 is a no-op when r0 is hardwired; it must not bypass either.
   assign wr_ok = we && !((ZERO_REG != 0) && (wa == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_reg[wa] <= wd;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .iss_v    (iss_v),
      .iss_rd   (iss_rd),
      .we       (we),
      .wa       (wa),
      .flush    (flush),
      .busy     (busy),
      .busy_any (busy_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic              hit;
         logic              is_zero;
         assign addr    = ra[rf_lsb(gi, ADDR_W) +: ADDR_W];
         assign hit     = (BYPASS != 0) && wr_ok && (wa == addr);
         assign is_zero = (ZERO_REG != 0) && (addr == '0);
         assign rd[rf_lsb(gi, DATA_W) +: DATA_W] = is_zero ? '0 :
                                                   hit     ? wd : mem_reg[addr];
         assign rd_busy[gi] = busy[addr] && !hit;
      end
   endgenerate

endmodule

// File: tb/tb_rf_param_sb.sv
// Directed scoreboard bench: stimulus pushes expected outputs, a negedge monitor
// pops and compares for a bypassing instance and a non-bypassing instance.
module tb_rf_param_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [9:0]  ra = '0;
   logic        iss_v = 1'b0;
   logic [4:0]  iss_rd = '0;
   logic        flush = 1'b0;
   logic        chk = 1'b0;

   logic [63:0] rd, rd_nb;
   logic [1:0]  rd_busy, rd_busy_nb;
   logic        busy_any, busy_any_nb;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  bz;
      logic        any;
      logic [31:0] rd1_nb;
      logic [1:0]  bz_nb;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   rf_param_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
      .rd_busy(rd_busy), .iss_v(iss_v), .iss_rd(iss_rd), .flush(flush),
      .busy_any(busy_any)
   );

   rf_param_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
      .rd_busy(rd_busy_nb), .iss_v(iss_v), .iss_rd(iss_rd), .flush(flush),
      .busy_any(busy_any_nb)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   // Monitor: outputs are presented whenever chk is high; compare at the falling edge.
   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL underflow: got output with no expected entry");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.name, ".rd0"},      rd[31:0],            e.rd0);
            cmp({e.name, ".rd1"},      rd[63:32],           e.rd1);
            cmp({e.name, ".rd_busy"},  {30'd0, rd_busy},    {30'd0, e.bz});
            cmp({e.name, ".busy_any"}, {31'd0, busy_any},   {31'd0, e.any});
            cmp({e.name, ".nb_rd1"},   rd_nb[63:32],        e.rd1_nb);
            cmp({e.name, ".nb_busy"},  {30'd0, rd_busy_nb}, {30'd0, e.bz_nb});
            $display("chk %-16s rd0=%08h rd1=%08h bz=%b any=%b nb_rd1=%08h nb_bz=%b",
                     e.name, rd[31:0], rd[63:32], rd_busy, busy_any, rd_nb[63:32], rd_busy_nb);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [31:0] rd0, input logic [31:0] rd1,
                             input logic [1:0] bz, input logic any,
                             input logic [31:0] rd1_nb, input logic [1:0] bz_nb);
      exp_t e;
      e.name = name; e.rd0 = rd0; e.rd1 = rd1; e.bz = bz; e.any = any;
      e.rd1_nb = rd1_nb; e.bz_nb = bz_nb;
      exp_q.push_back(e);
      chk = 1'b1;
      tick();
      chk = 1'b0;
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic iv, input logic [4:0] ir, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1);
      we = w; wa = a; wd = d; iss_v = iv; iss_rd = ir; flush = fl;
      ra = {r1, r0};
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      expect_out("reset_hold", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);
      rst = 1'b0;

      // T1: write r5 (bypassed this cycle), issue r6, then async reset mid-cycle
      drive(1, 5, 32'hDEADBEEF, 1, 6, 0, 5, 5);
      expect_out("t1_write", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 5, 6);
      expect_out("t1_pre", 32'hDEADBEEF, 32'h0, 2'b10, 1'b1, 32'h0, 2'b10);
      drive(0, 0, 0, 0, 0, 0, 5, 6);
      rst = 1'b1;
      expect_out("t1_reset", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);
      rst = 1'b0;

      // T2: write then read on both ports
      drive(1, 3, 32'h12345678, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 3, 3);
      expect_out("t2_read", 32'h12345678, 32'h12345678, 2'b00, 1'b0, 32'h12345678, 2'b00);

      // T3: r0 write and issue are both ignored
      drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
      expect_out("t3_same", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      expect_out("t3_after", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);

      // T4: same-cycle bypass vs. no-bypass build
      drive(1, 7, 32'hA5A5A5A5, 0, 0, 0, 3, 7);
      expect_out("t4_bypass", 32'h12345678, 32'hA5A5A5A5, 2'b00, 1'b0, 32'h0, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 3, 7);
      expect_out("t4_after", 32'h12345678, 32'hA5A5A5A5, 2'b00, 1'b0, 32'hA5A5A5A5, 2'b00);

      // T5: scoreboard issue / retire / simultaneous issue+retire
      drive(0, 0, 0, 1, 9, 0, 9, 9);
      expect_out("t5_issue_same", 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 9, 9);
      expect_out("t5_busy", 32'h0, 32'h0, 2'b11, 1'b1, 32'h0, 2'b11);
      drive(1, 9, 32'h00000099, 0, 0, 0, 9, 3);
      expect_out("t5_retire", 32'h00000099, 32'h12345678, 2'b00, 1'b1, 32'h12345678, 2'b01);
      drive(0, 0, 0, 0, 0, 0, 9, 9);
      expect_out("t5_cleared", 32'h00000099, 32'h00000099, 2'b00, 1'b0, 32'h00000099, 2'b00);
      drive(1, 9, 32'h000000AA, 1, 9, 0, 9, 9);
      expect_out("t5_both", 32'h000000AA, 32'h000000AA, 2'b00, 1'b0, 32'h00000099, 2'b00);
      drive(0, 0, 0, 0, 0, 0, 9, 9);
      expect_out("t5_both_after", 32'h000000AA, 32'h000000AA, 2'b11, 1'b1, 32'h000000AA, 2'b11);

      // T6: several producers in flight, then flush overriding a same-cycle issue
      drive(0, 0, 0, 1, 1, 0, 1, 2);
      tick();
      drive(0, 0, 0, 1, 2, 0, 1, 2);
      tick();
      drive(0, 0, 0, 1, 3, 0, 1, 2);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 2);
      expect_out("t6_busy", 32'h0, 32'h0, 2'b11, 1'b1, 32'h0, 2'b11);
      drive(0, 0, 0, 1, 4, 1, 3, 4);
      expect_out("t6_flush_same", 32'h12345678, 32'h0, 2'b01, 1'b1, 32'h0, 2'b01);
      drive(0, 0, 0, 0, 0, 0, 4, 9);
      expect_out("t6_after", 32'h0, 32'h000000AA, 2'b00, 1'b0, 32'h000000AA, 2'b00);

      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unconsumed entries expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
